// File: rtl/matrix_multiplier_param.sv
// NxN streaming matrix multiplier: loads A/B row-major,
// then computes C = A x B on one time-shared MAC.
module matrix_multiplier_param #(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int OW    = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          NRST,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [OW-1:0] out,
  output logic          out_strobe,
  output logic          busy,
  output logic          done
);

  localparam int NN = N*N;
  localparam int IW = $clog2(NN);
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_e;

  state_e        state_q;
  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] b_q [NN];
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] ai_q;
  logic [IW-1:0] bi_q;
  logic [KW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] out_q;
  logic          rdy_q;
  logic          busy_q;
  logic          stb_q;
  logic          done_q;

  logic [OW-1:0] ea;
  logic [OW-1:0] eb;
  logic [OW-1:0] prod;
  logic [OW-1:0] sum;
  logic          beat;
  logic          last_beat;
  logic          elem_end;
  logic          row_end;
  logic          last_elem;

  assign beat      = (state_q == LOAD) && in_valid;
  assign last_beat = beat && (cnt_q == IW'(NN-1));
  assign elem_end  = (k_q == KW'(N-1));
  assign row_end   = (j_q == KW'(N-1));
  // ai_q sits on the last column of the last row here
  assign last_elem = row_end && (ai_q == IW'(NN-1));

  assign in_ready   = rdy_q;
  assign busy       = busy_q;
  assign out        = out_q;
  assign out_strobe = stb_q;
  assign done       = done_q;

  // Extend operands to OW so the product and sum cannot overflow
  always_comb begin
    ea   = {{(OW-DW){(SIGNED != 0) && a_q[ai_q][DW-1]}}, a_q[ai_q]};
    eb   = {{(OW-DW){(SIGNED != 0) && b_q[bi_q][DW-1]}}, b_q[bi_q]};
    prod = ea * eb;
    sum  = ((k_q == '0) ? '0 : acc_q) + prod;
  end

  // Operand storage, written one beat at a time during LOAD
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < NN; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (beat) begin
      a_q[cnt_q] <= A;
      b_q[cnt_q] <= B;
    end
  end

  // Control FSM; the extra CALC cycle keeps busy high with done
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ai_q    <= '0;
      bi_q    <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (last_beat) begin
            state_q <= CALC;
            rdy_q   <= 1'b0;
            ai_q    <= '0;
            bi_q    <= '0;
            j_q     <= '0;
            k_q     <= '0;
          end else if (beat) begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        CALC: begin
          if (done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= sum;
            if (!elem_end) begin
              k_q  <= k_q + KW'(1);
              ai_q <= ai_q + IW'(1);
              bi_q <= bi_q + IW'(N);
            end else begin
              k_q   <= '0;
              out_q <= sum;
              stb_q <= 1'b1;
              if (last_elem) begin
                done_q <= 1'b1;
              end else if (row_end) begin
                j_q  <= '0;
                ai_q <= ai_q + IW'(1);
                bi_q <= '0;
              end else begin
                j_q  <= j_q + KW'(1);
                ai_q <= ai_q - IW'(N-1);
                bi_q <= bi_q - IW'((N-1)*N) + IW'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiplier_param.sv
// Bench for matrix_multiplier_param: three configurations
// checked against a plain-arithmetic matrix product.
module tb_matrix_multiplier_param;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  st;
  logic [2:0]  iv;
  logic [2:0]  rdy;
  logic [2:0]  stb;
  logic [2:0]  bsy;
  logic [2:0]  dne;
  logic [7:0]  av [3];
  logic [7:0]  bv [3];
  logic [16:0] out0;
  logic [16:0] out1;
  logic [17:0] out2;
  logic [17:0] o_out [3];

  logic [7:0]  ta [64];
  logic [7:0]  tb_ [64];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    o_out[0] = {1'b0, out0};
    o_out[1] = {1'b0, out1};
    o_out[2] = out2;
  end

  matrix_multiplier_param #(.N(2), .DW(8), .SIGNED(0)) u0 (
    .clk(clk), .NRST(nrst), .start(st[0]), .in_valid(iv[0]),
    .in_ready(rdy[0]), .A(av[0]), .B(bv[0]), .out(out0),
    .out_strobe(stb[0]), .busy(bsy[0]), .done(dne[0]));

  matrix_multiplier_param #(.N(2), .DW(8), .SIGNED(1)) u1 (
    .clk(clk), .NRST(nrst), .start(st[1]), .in_valid(iv[1]),
    .in_ready(rdy[1]), .A(av[1]), .B(bv[1]), .out(out1),
    .out_strobe(stb[1]), .busy(bsy[1]), .done(dne[1]));

  matrix_multiplier_param #(.N(3), .DW(8), .SIGNED(0)) u2 (
    .clk(clk), .NRST(nrst), .start(st[2]), .in_valid(iv[2]),
    .in_ready(rdy[2]), .A(av[2]), .B(bv[2]), .out(out2),
    .out_strobe(stb[2]), .busy(bsy[2]), .done(dne[2]));

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // gap: 0 contiguous, 1 every other cycle, 2 random
  task automatic run_mm(input int d, input int n, input bit sgn,
                        input int gap, input bit junk,
                        input bit stcalc, input bit rstmid);
    int nn;
    int ow;
    longint mask;
    longint exp_c [64];
    int c0;
    int k;
    int g;
    int idx;
    int ndone;
    int last;
    bit first;
    bit rd;
    nn   = n * n;
    ow   = (n <= 2) ? 17 : 18;
    mask = (64'sd1 <<< ow) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        longint s;
        s = 0;
        for (int kk = 0; kk < n; kk++) begin
          longint x;
          longint y;
          x = sgn ? longint'($signed(ta[i*n+kk])) : longint'(ta[i*n+kk]);
          y = sgn ? longint'($signed(tb_[kk*n+j])) : longint'(tb_[kk*n+j]);
          s += x * y;
        end
        exp_c[i*n+j] = s & mask;
      end

    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;

    k = 0;
    g = 0;
    c0 = cyc;
    first = 1'b1;
    while (k < nn) begin
      if (g > 500) begin
        chk("load_timeout", k, nn);
        break;
      end
      iv[d] = (gap == 0) ? 1'b1 :
              (gap == 1) ? (g % 2 == 0) : ($urandom_range(0, 2) != 0);
      av[d] = ta[k];
      bv[d] = tb_[k];
      if (first) begin
        chk("rdy_load", rdy[d], 1);
        first = 1'b0;
      end
      if (iv[d] && rdy[d]) begin
        c0 = cyc;
        k++;
      end
      g++;
      @(negedge clk);
    end

    iv[d] = junk;
    av[d] = 8'($urandom);
    bv[d] = 8'($urandom);
    chk("rdy_calc", rdy[d], 0);
    chk("busy_calc", bsy[d], 1);

    idx = 0;
    ndone = 0;
    last = -10;
    rd = 1'b0;
    while (cyc <= c0 + n*n*n + n + 6) begin
      st[d] = stcalc && (cyc == c0 + 2);
      if (rstmid && !rd && idx == 1) begin
        nrst = 1'b0;
        #1;
        chk("rst_out", o_out[d], 0);
        chk("rst_stb", stb[d], 0);
        chk("rst_busy", bsy[d], 0);
        chk("rst_rdy", rdy[d], 0);
        chk("rst_done", dne[d], 0);
        rd = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
      end else if (rd) begin
        chk("stb_after_rst", stb[d], 0);
      end else if (stb[d]) begin
        chk($sformatf("out%0d", idx), o_out[d], exp_c[idx]);
        chk("stb_cyc", cyc, c0 + n + 1 + idx * n);
        chk("done_flag", dne[d], (idx == nn - 1) ? 1 : 0);
        if (idx == nn - 1) begin
          chk("busy_at_done", bsy[d], 1);
          last = cyc;
        end
        if (idx < nn) idx++;
      end else begin
        chk("no_done_wo_stb", dne[d], 0);
      end
      if (dne[d]) ndone++;
      if (!rd && cyc == last + 1) chk("busy_after", bsy[d], 0);
      @(negedge clk);
    end
    st[d] = 1'b0;
    iv[d] = 1'b0;

    chk("stb_count", idx, rd ? 1 : nn);
    chk("done_count", ndone, rd ? 0 : 1);
    if (!rd) chk("out_hold", o_out[d], exp_c[nn-1]);
  endtask

  task automatic set_t1();
    for (int i = 0; i < 4; i++) begin
      ta[i]  = 8'(i + 1);
      tb_[i] = 8'(i + 5);
    end
  endtask

  initial begin
    nrst = 1'b0;
    st = '0;
    iv = '0;
    for (int d = 0; d < 3; d++) begin
      av[d] = '0;
      bv[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_out", o_out[d], 0);
      chk("reset_stb", stb[d], 0);
      chk("reset_busy", bsy[d], 0);
      chk("reset_rdy", rdy[d], 0);
      chk("reset_done", dne[d], 0);
    end
    nrst = 1'b1;
    @(negedge clk);

    set_t1();
    run_mm(0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ta[i]  = 8'hFF;
      tb_[i] = 8'hFF;
    end
    run_mm(0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ta[i]  = 8'hFF;
      tb_[i] = 8'h7F;
    end
    run_mm(1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      ta[i]  = (i % 4 == 0) ? 8'd1 : 8'd0;
      tb_[i] = 8'(i + 1);
    end
    run_mm(2, 3, 1'b0, 1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ta[i]  = 8'($urandom);
      tb_[i] = 8'($urandom);
    end
    run_mm(0, 2, 1'b0, 2, 1'b0, 1'b1, 1'b0);

    set_t1();
    run_mm(0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_mm(0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 9; i++) begin
          ta[i]  = 8'($urandom);
          tb_[i] = 8'($urandom);
        end
        run_mm(d, (d == 2) ? 3 : 2, d == 1, 2, r[0], 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
